// File: rtl/and16.sv
// and16: 16-bit bitwise AND with zero flag and popcount, plus a registered copy of result and zero flag.
// Latency: out/zero/ones combinational, out_q/zero_q one clk after a/b; no backpressure.
module and16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  output logic [WIDTH-1:0]           out,
  input  logic                       clk,
  input  logic                       reset,
  output logic [WIDTH-1:0]           out_q,
  output logic                       zero,
  output logic                       zero_q,
  output logic [$clog2(WIDTH+1)-1:0] ones
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] out_d;
  logic             zero_d;
  logic [CW-1:0]    ones_sum;

  // Combinational path never touches clk/reset, so it stays valid with them floating.
  always_comb begin
    out_d  = a & b;
    zero_d = ~|out_d;
  end

  always_comb begin
    ones_sum = '0;
    for (int k = 0; k < WIDTH; k++) begin
      ones_sum = ones_sum + CW'(out_d[k]);
    end
  end

  assign out  = out_d;
  assign zero = zero_d;
  assign ones = ones_sum;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      out_q  <= out_d;
      zero_q <= zero_d;
    end
  end

endmodule

// File: tb/tb_and16.sv
// Directed bench for and16: vector table, walking ones, floating-clock instance, registered path.
module tb_and16;

  logic [15:0] a, b, out, out_q;
  logic        clk, reset, zero, zero_q;
  logic [4:0]  ones;

  logic [15:0] a_f, b_f, out_f, out_q_f;
  logic        clk_f, rst_f, zero_f, zero_q_f;
  logic [4:0]  ones_f;

  int checks = 0;
  int errors = 0;

  and16 u_dut (
    .a(a), .b(b), .out(out), .clk(clk), .reset(reset),
    .out_q(out_q), .zero(zero), .zero_q(zero_q), .ones(ones)
  );

  and16 u_float (
    .a(a_f), .b(b_f), .out(out_f), .clk(clk_f), .reset(rst_f),
    .out_q(out_q_f), .zero(zero_f), .zero_q(zero_q_f), .ones(ones_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_out;
    logic        exp_zero;
    logic [4:0]  exp_ones;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  initial begin
    vec_t vecs[6];
    logic [15:0] one;
    one = 16'h0001;

    vecs[0] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 5'd16};
    vecs[1] = '{16'hAAAA, 16'hF0F0, 16'hA0A0, 1'b0, 5'd4};
    vecs[2] = '{16'hAAAA, 16'h5555, 16'h0000, 1'b1, 5'd0};
    vecs[3] = '{16'h0000, 16'hFFFF, 16'h0000, 1'b1, 5'd0};
    vecs[4] = '{16'h8001, 16'hFFFF, 16'h8001, 1'b0, 5'd2};
    vecs[5] = '{16'h7FFE, 16'hFFF7, 16'h7FF6, 1'b0, 5'd13};

    a = '0; b = '0; reset = 1'b0;
    a_f = '0; b_f = '0; clk_f = 1'bz; rst_f = 1'bz;

    // Table-driven combinational checks
    for (int v = 0; v < 6; v++) begin
      a = vecs[v].a; b = vecs[v].b;
      #1;
      chk("tbl_out",  32'(out),  32'(vecs[v].exp_out));
      chk("tbl_zero", 32'(zero), 32'(vecs[v].exp_zero));
      chk("tbl_ones", 32'(ones), 32'(vecs[v].exp_ones));
    end

    // Walking ones
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        a = one << i; b = one << j;
        #1;
        if (i == j) begin
          chk("walk_out",  32'(out),  32'(one << i));
          chk("walk_zero", 32'(zero), 32'd0);
          chk("walk_ones", 32'(ones), 32'd1);
        end else begin
          chk("walk_out",  32'(out),  32'd0);
          chk("walk_zero", 32'(zero), 32'd1);
          chk("walk_ones", 32'(ones), 32'd0);
        end
      end
    end

    // Instance with clock and reset left floating
    a_f = 16'h00FF; b_f = 16'h0F0F;
    #1;
    chk("float_out",   32'(out_f), 32'h000F);
    chk("float_known", 32'($isunknown(out_f)), 32'd0);
    chk("float_ones",  32'(ones_f), 32'd4);

    // Registered path: reset for one edge
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_out_q",  32'(out_q),  32'h0000);
    chk("rst_zero_q", 32'(zero_q), 32'd1);

    reset = 1'b0;
    a = 16'h1234; b = 16'hFFFF;
    #2;
    chk("pre_edge_out_q",  32'(out_q),  32'h0000);
    chk("pre_edge_zero_q", 32'(zero_q), 32'd1);
    chk("comb_out",        32'(out),    32'h1234);
    @(posedge clk); #1;
    chk("edge1_out_q",  32'(out_q),  32'h1234);
    chk("edge1_zero_q", 32'(zero_q), 32'd0);

    // Mid-operation reset takes effect only at the next edge
    #2;
    reset = 1'b1;
    #2;
    chk("midrst_hold_out_q", 32'(out_q), 32'h1234);
    chk("midrst_out",        32'(out),   32'h1234);
    @(posedge clk); #1;
    chk("midrst_out_q",  32'(out_q),  32'h0000);
    chk("midrst_zero_q", 32'(zero_q), 32'd1);
    chk("midrst_out2",   32'(out),    32'h1234);
    chk("midrst_ones",   32'(ones),   32'd5);

    reset = 1'b0;
    @(posedge clk); #1;
    chk("recover_out_q", 32'(out_q), 32'h1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
